// File: rtl/ddr_burst_writer.sv
// ddr_burst_writer: takes one DDR write burst (data plus byte masks) per
// ready/start handshake and serializes it one beat per clock2x cycle onto
// DQ/DM. The burst is framed by a DQS strobe with a configurable preamble
// and a one-cycle postamble. A start taken on the last beat chains the next
// burst with no strobe gap. Every output comes straight from a flop; the
// next output values are decoded from the next-state values.
module ddr_burst_writer #(
   parameter int DATA_W   = 64,
   parameter int BL       = 8,
   parameter int PREAMBLE = 1
) (
   input  logic                             clock2x,
   input  logic                             reset,
   input  logic                             start,
   input  logic [BL-1:0][DATA_W-1:0]        burst_data,
   input  logic [BL-1:0][DATA_W/8-1:0]      burst_mask,
   output logic                             ready,
   output logic                             done,
   output logic [DATA_W-1:0]                dq,
   output logic [DATA_W/8-1:0]              dm,
   output logic                             dq_oe,
   output logic                             dqs_t,
   output logic                             dqs_c,
   output logic                             dqs_oe
);

   localparam int MW = DATA_W / 8;
   localparam int KW = (BL > 1) ? $clog2(BL) : 1;
   localparam int PW = (PREAMBLE > 1) ? $clog2(PREAMBLE) : 1;
   localparam logic [KW-1:0] K_LAST = KW'(BL - 1);
   localparam logic [PW-1:0] P_LAST = PW'(PREAMBLE - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PRE   = 2'd1,
      BURST = 2'd2,
      POST  = 2'd3
   } state_t;

   // control state
   state_t                      state_q, state_d;
   logic [KW-1:0]               k_q, k_d;
   logic [PW-1:0]               pre_q, pre_d;

   // burst buffer
   logic [BL-1:0][DATA_W-1:0]   buf_q, buf_d;
   logic [BL-1:0][MW-1:0]       mask_q, mask_d;

   // registered outputs
   logic                        ready_q, ready_d;
   logic                        done_q, done_d;
   logic [DATA_W-1:0]           dq_q, dq_d;
   logic [MW-1:0]               dm_q, dm_d;
   logic                        dq_oe_q, dq_oe_d;
   logic                        dqs_t_q, dqs_t_d;
   logic                        dqs_oe_q, dqs_oe_d;

   // A request is only taken when we advertised ready and are not in reset.
   logic                        accept;
   assign accept = start && ready_q && !reset;

   // Next-state logic: preamble count, beat count, buffer load and chaining.
   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      pre_d   = pre_q;
      buf_d   = buf_q;
      mask_d  = mask_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               buf_d   = burst_data;
               mask_d  = burst_mask;
               pre_d   = '0;
               state_d = PRE;
            end
         end
         PRE: begin
            if (pre_q == P_LAST) begin
               k_d     = '0;
               state_d = BURST;
            end else begin
               pre_d = pre_q + PW'(1);
            end
         end
         BURST: begin
            if (k_q == K_LAST) begin
               // BL is a power of two, so the wrap to 0 is also the chain point
               k_d = '0;
               if (accept) begin
                  buf_d  = burst_data;
                  mask_d = burst_mask;
               end else begin
                  state_d = POST;
               end
            end else begin
               k_d = k_q + KW'(1);
            end
         end
         POST: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      // Synchronous reset abandons any burst in flight with no postamble.
      if (reset) begin
         state_d = IDLE;
         k_d     = '0;
         pre_d   = '0;
      end
   end

   // Output decode from the next state, so the registered outputs line up with it.
   always_comb begin
      ready_d  = 1'b0;
      done_d   = 1'b0;
      dq_d     = '0;
      dm_d     = '0;
      dq_oe_d  = 1'b0;
      dqs_t_d  = 1'b0;
      dqs_oe_d = 1'b0;
      case (state_d)
         IDLE: begin
            ready_d = 1'b1;
         end
         PRE, POST: begin
            // strobe driven low, data bus released
            dqs_oe_d = 1'b1;
         end
         BURST: begin
            dq_d     = buf_d[k_d];
            dm_d     = mask_d[k_d];
            dq_oe_d  = 1'b1;
            dqs_oe_d = 1'b1;
            // even beats rise, so the strobe is low after every last beat
            dqs_t_d  = ~k_d[0];
            if (k_d == K_LAST) begin
               done_d  = 1'b1;
               ready_d = 1'b1;
            end
         end
         default: begin
            ready_d = 1'b0;
         end
      endcase
   end

   // FSM state register.
   always_ff @(posedge clock2x) begin
      state_q <= state_d;
      k_q     <= k_d;
      pre_q   <= pre_d;
   end

   // Burst buffer and output registers.
   always_ff @(posedge clock2x) begin
      buf_q    <= buf_d;
      mask_q   <= mask_d;
      ready_q  <= ready_d;
      done_q   <= done_d;
      dq_q     <= dq_d;
      dm_q     <= dm_d;
      dq_oe_q  <= dq_oe_d;
      dqs_t_q  <= dqs_t_d;
      dqs_oe_q <= dqs_oe_d;
   end

   assign ready  = ready_q;
   assign done   = done_q;
   assign dq     = dq_q;
   assign dm     = dm_q;
   assign dq_oe  = dq_oe_q;
   assign dqs_t  = dqs_t_q;
   assign dqs_c  = ~dqs_t_q;
   assign dqs_oe = dqs_oe_q;

endmodule

// File: tb/tb_ddr_burst_writer.sv
// Bench for ddr_burst_writer: one instance with PREAMBLE=1 tracked by a
// frame-queue reference model, and one with PREAMBLE=3 for the preamble sweep.
module tb_ddr_burst_writer;

   localparam int DATA_W = 64;
   localparam int BL     = 8;
   localparam int MW     = DATA_W / 8;
   localparam int VW     = DATA_W + MW + 6;

   // dq, dm, dq_oe, dqs_t, dqs_c, dqs_oe, done, ready
   localparam logic [VW-1:0] IDLE_VEC = {64'h0, 8'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

   logic clock2x = 1'b0;
   always #5 clock2x = ~clock2x;

   logic                        reset, start, start_b;
   logic [BL-1:0][DATA_W-1:0]   burst_data;
   logic [BL-1:0][MW-1:0]       burst_mask;

   logic                        ready_a, done_a, dq_oe_a, dqs_t_a, dqs_c_a, dqs_oe_a;
   logic [DATA_W-1:0]           dq_a;
   logic [MW-1:0]               dm_a;
   logic                        ready_b, done_b, dq_oe_b, dqs_t_b, dqs_c_b, dqs_oe_b;
   logic [DATA_W-1:0]           dq_b;
   logic [MW-1:0]               dm_b;

   ddr_burst_writer #(.DATA_W(DATA_W), .BL(BL), .PREAMBLE(1)) dut_a (
      .clock2x(clock2x), .reset(reset), .start(start),
      .burst_data(burst_data), .burst_mask(burst_mask),
      .ready(ready_a), .done(done_a), .dq(dq_a), .dm(dm_a), .dq_oe(dq_oe_a),
      .dqs_t(dqs_t_a), .dqs_c(dqs_c_a), .dqs_oe(dqs_oe_a)
   );

   ddr_burst_writer #(.DATA_W(DATA_W), .BL(BL), .PREAMBLE(3)) dut_b (
      .clock2x(clock2x), .reset(reset), .start(start_b),
      .burst_data(burst_data), .burst_mask(burst_mask),
      .ready(ready_b), .done(done_b), .dq(dq_b), .dm(dm_b), .dq_oe(dq_oe_b),
      .dqs_t(dqs_t_b), .dqs_c(dqs_c_b), .dqs_oe(dqs_oe_b)
   );

   logic [VW-1:0] obs_a, obs_b;
   assign obs_a = {dq_a, dm_a, dq_oe_a, dqs_t_a, dqs_c_a, dqs_oe_a, done_a, ready_a};
   assign obs_b = {dq_b, dm_b, dq_oe_b, dqs_t_b, dqs_c_b, dqs_oe_b, done_b, ready_b};

   // Expected bus state for one clock2x cycle.
   typedef struct packed {
      logic [DATA_W-1:0] dq;
      logic [MW-1:0]     dm;
      logic              dq_oe;
      logic              dqs_t;
      logic              dqs_oe;
      logic              done;
      logic              ready;
   } frame_t;

   frame_t cur;
   frame_t fut[$];
   int     n_checks = 0;
   int     n_fail   = 0;

   function automatic frame_t idle_frame();
      frame_t f;
      f = '0;
      f.ready = 1'b1;
      return f;
   endfunction

   // Preamble and postamble cycles look the same on the bus.
   function automatic frame_t strobe_frame();
      frame_t f;
      f = '0;
      f.dqs_oe = 1'b1;
      return f;
   endfunction

   function automatic frame_t beat_frame(input logic [DATA_W-1:0] d, input logic [MW-1:0] m, input int i);
      frame_t f;
      f.dq     = d;
      f.dm     = m;
      f.dq_oe  = 1'b1;
      f.dqs_t  = (i % 2 == 0);
      f.dqs_oe = 1'b1;
      f.done   = (i == BL - 1);
      f.ready  = (i == BL - 1);
      return f;
   endfunction

   function automatic logic [VW-1:0] exp_vec(input frame_t f);
      return {f.dq, f.dm, f.dq_oe, f.dqs_t, ~f.dqs_t, f.dqs_oe, f.done, f.ready};
   endfunction

   // Apply the currently driven inputs to the model of dut_a, then move one cycle.
   task automatic advance();
      logic acc;
      acc = start && cur.ready && !reset;
      if (reset) begin
         fut.delete();
         cur = idle_frame();
      end else begin
         if (acc) begin
            fut.delete();
            if (!cur.done) fut.push_back(strobe_frame());
            for (int i = 0; i < BL; i++) fut.push_back(beat_frame(burst_data[i], burst_mask[i], i));
            fut.push_back(strobe_frame());
         end
         if (fut.size() > 0) cur = fut.pop_front();
         else cur = idle_frame();
      end
      @(posedge clock2x);
      @(negedge clock2x);
   endtask

   task automatic rand_inputs();
      for (int i = 0; i < BL; i++) begin
         burst_data[i] = {$urandom, $urandom};
         burst_mask[i] = 8'($urandom);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      start = 1'b1;
      rand_inputs();
      advance();
      advance();
      n_checks++;
      if (obs_a !== IDLE_VEC) begin
         n_fail++;
         $display("FAIL reset_hold: got %h expected %h", obs_a, IDLE_VEC);
      end
      reset = 1'b0;
      start = 1'b0;
      for (int c = 0; c < 3; c++) begin
         n_checks++;
         if (obs_a !== IDLE_VEC || obs_a !== exp_vec(cur)) begin
            n_fail++;
            $display("FAIL reset_idle c%0d: got %h expected %h", c, obs_a, IDLE_VEC);
         end
         n_checks++;
         if (obs_b !== IDLE_VEC) begin
            n_fail++;
            $display("FAIL reset_idle_b c%0d: got %h expected %h", c, obs_b, IDLE_VEC);
         end
         advance();
      end
   endtask

   task automatic test_single();
      logic [DATA_W-1:0] beat;
      for (int i = 0; i < BL; i++) begin
         beat = 64'h1111_1111_1111_1111 * i;
         burst_data[i] = beat;
         burst_mask[i] = '0;
      end
      start = 1'b1;
      advance();
      start = 1'b0;
      rand_inputs();
      for (int c = 1; c <= 11; c++) begin
         n_checks++;
         if (obs_a !== exp_vec(cur)) begin
            n_fail++;
            $display("FAIL single_model c%0d: got %h expected %h", c, obs_a, exp_vec(cur));
         end
         if (c >= 2 && c <= 9) begin
            beat = 64'h1111_1111_1111_1111 * (c - 2);
            n_checks++;
            if (dq_a !== beat || dqs_t_a !== ((c - 2) % 2 == 0)) begin
               n_fail++;
               $display("FAIL single_beat c%0d: got dq=%h dqs_t=%b expected dq=%h", c, dq_a, dqs_t_a, beat);
            end
         end
         n_checks++;
         if (done_a !== (c == 9)) begin
            n_fail++;
            $display("FAIL single_done c%0d: got %b expected %b", c, done_a, (c == 9));
         end
         if (c == 10) begin
            n_checks++;
            if ({dqs_oe_a, dq_oe_a, ready_a, dqs_t_a} !== 4'b1000) begin
               n_fail++;
               $display("FAIL single_post: got %b expected 1000", {dqs_oe_a, dq_oe_a, ready_a, dqs_t_a});
            end
         end
         if (c == 11) begin
            n_checks++;
            if (ready_a !== 1'b1) begin
               n_fail++;
               $display("FAIL single_ready: got %b expected 1", ready_a);
            end
         end
         advance();
      end
   endtask

   task automatic test_preamble();
      logic [BL-1:0][DATA_W-1:0] d;
      logic [BL-1:0][MW-1:0]     m;
      frame_t                    e;
      rand_inputs();
      d = burst_data;
      m = burst_mask;
      n_checks++;
      if (ready_b !== 1'b1) begin
         n_fail++;
         $display("FAIL pre_ready: got %b expected 1", ready_b);
      end
      start_b = 1'b1;
      advance();
      start_b = 1'b0;
      rand_inputs();
      for (int t = 1; t <= 13; t++) begin
         if (t <= 3) e = strobe_frame();
         else if (t <= 11) e = beat_frame(d[t-4], m[t-4], t - 4);
         else if (t == 12) e = strobe_frame();
         else e = idle_frame();
         n_checks++;
         if (obs_b !== exp_vec(e)) begin
            n_fail++;
            $display("FAIL preamble3 c%0d: got %h expected %h", t, obs_b, exp_vec(e));
         end
         advance();
      end
   endtask

   task automatic test_back_to_back();
      logic sent, prev_sent;
      int   strobe_only;
      sent = 1'b0;
      prev_sent = 1'b0;
      strobe_only = 0;
      rand_inputs();
      start = 1'b1;
      advance();
      for (int c = 1; c < 30; c++) begin
         start = 1'b0;
         if (cur.done && !sent) begin
            for (int i = 0; i < BL; i++) begin
               burst_data[i] = 64'h0A0 + 64'(i);
               burst_mask[i] = '0;
            end
            start = 1'b1;
            sent = 1'b1;
         end
         n_checks++;
         if (obs_a !== exp_vec(cur)) begin
            n_fail++;
            $display("FAIL b2b_model c%0d: got %h expected %h", c, obs_a, exp_vec(cur));
         end
         if (prev_sent) begin
            n_checks++;
            if (dq_a !== 64'hA0 || dqs_t_a !== 1'b1 || dq_oe_a !== 1'b1) begin
               n_fail++;
               $display("FAIL b2b_first c%0d: got dq=%h dqs_t=%b expected dq=a0 dqs_t=1", c, dq_a, dqs_t_a);
            end
         end
         prev_sent = start;
         if (c >= 2 && dqs_oe_a === 1'b1 && dq_oe_a === 1'b0) strobe_only++;
         advance();
      end
      start = 1'b0;
      n_checks++;
      if (sent !== 1'b1 || strobe_only !== 1) begin
         n_fail++;
         $display("FAIL b2b_post_count: got %0d (chained=%b) expected 1", strobe_only, sent);
      end
   endtask

   task automatic test_mask_ignore();
      logic [BL-1:0][DATA_W-1:0] d0;
      logic [MW-1:0]             em;
      rand_inputs();
      for (int i = 0; i < BL; i++) burst_mask[i] = '0;
      burst_mask[3] = 8'h0F;
      d0 = burst_data;
      start = 1'b1;
      advance();
      for (int c = 1; c <= 11; c++) begin
         start = 1'b0;
         if (c == 1 || c == 5) begin
            rand_inputs();
            start = 1'b1;
         end
         n_checks++;
         if (obs_a !== exp_vec(cur)) begin
            n_fail++;
            $display("FAIL mask_model c%0d: got %h expected %h", c, obs_a, exp_vec(cur));
         end
         if (c >= 2 && c <= 9) begin
            em = ((c - 2) == 3) ? 8'h0F : 8'h00;
            n_checks++;
            if (dq_a !== d0[c-2] || dm_a !== em) begin
               n_fail++;
               $display("FAIL mask_beat c%0d: got dq=%h dm=%h expected dq=%h dm=%h", c, dq_a, dm_a, d0[c-2], em);
            end
         end
         advance();
      end
      start = 1'b0;
   endtask

   task automatic test_reset_mid();
      logic [BL-1:0][DATA_W-1:0] d;
      rand_inputs();
      d = burst_data;
      start = 1'b1;
      advance();
      start = 1'b0;
      for (int c = 1; c <= 6; c++) begin
         n_checks++;
         if (obs_a !== exp_vec(cur)) begin
            n_fail++;
            $display("FAIL rmid_model c%0d: got %h expected %h", c, obs_a, exp_vec(cur));
         end
         if (c == 6) begin
            n_checks++;
            if (dq_a !== d[4]) begin
               n_fail++;
               $display("FAIL rmid_beat4: got %h expected %h", dq_a, d[4]);
            end
            reset = 1'b1;
         end
         advance();
      end
      reset = 1'b0;
      for (int c = 0; c < 6; c++) begin
         n_checks++;
         if (obs_a !== IDLE_VEC || obs_a !== exp_vec(cur)) begin
            n_fail++;
            $display("FAIL rmid_idle c%0d: got %h expected %h", c, obs_a, IDLE_VEC);
         end
         advance();
      end
      rand_inputs();
      d = burst_data;
      start = 1'b1;
      advance();
      start = 1'b0;
      for (int c = 1; c <= 11; c++) begin
         n_checks++;
         if (obs_a !== exp_vec(cur)) begin
            n_fail++;
            $display("FAIL rmid_restart c%0d: got %h expected %h", c, obs_a, exp_vec(cur));
         end
         if (c == 2) begin
            n_checks++;
            if (dq_a !== d[0] || dqs_t_a !== 1'b1) begin
               n_fail++;
               $display("FAIL rmid_first: got dq=%h dqs_t=%b expected dq=%h dqs_t=1", dq_a, dqs_t_a, d[0]);
            end
         end
         advance();
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         reset = ($urandom_range(0, 79) == 0);
         if (cur.done) start = ($urandom_range(0, 1) == 1);
         else start = ($urandom_range(0, 3) == 0);
         rand_inputs();
         n_checks++;
         if (obs_a !== exp_vec(cur)) begin
            n_fail++;
            $display("FAIL random c%0d: got %h expected %h", c, obs_a, exp_vec(cur));
         end
         advance();
      end
      reset = 1'b0;
      start = 1'b0;
      for (int c = 0; c < 16; c++) begin
         n_checks++;
         if (obs_a !== exp_vec(cur)) begin
            n_fail++;
            $display("FAIL random_drain c%0d: got %h expected %h", c, obs_a, exp_vec(cur));
         end
         advance();
      end
   endtask

   initial begin
      reset      = 1'b1;
      start      = 1'b0;
      start_b    = 1'b0;
      burst_data = '0;
      burst_mask = '0;
      cur        = idle_frame();
      @(negedge clock2x);
      test_reset();
      test_single();
      test_preamble();
      test_back_to_back();
      test_mask_ignore();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "timeout");
   end

endmodule
